// File: rtl/depack_ctrl.sv
// depack_ctrl
// Sits between the network depacketizer and the core. It pulls flits out of
// the depacketizer, checks that every packet is well formed and passes the
// good flits to the core through a single registered output slot. Malformed
// traffic is dropped and reported through pkt_err / err_code / err_cnt.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flit_valid, flit_type    flit present / type (00 body, 01 head, 10 tail, 11 single)
//   flit_payload, flit_sn    flit payload and 5-bit sequence number
//   flit_src                 source router coordinates {x, y}
//   depack_enable            read strobe back to the depacketizer
//   core_valid, core_ready   output slot handshake
//   core_data, core_src      output slot payload and source
//   core_sop, core_eop       start / end of packet markers for the slot
//   pkt_err, err_code        one-cycle error pulse and sticky error cause
//                            (0 length, 1 type, 2 sequence number, 3 source)
//   pkt_ok_cnt, err_cnt      completed packet count (wraps), error count (saturates)
module depack_ctrl #(
  parameter int PAYLOAD_WIDTH = 32,
  parameter int XY_WIDTH      = 4,
  parameter int MAX_FLITS     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flit_valid,
  input  logic [1:0]               flit_type,
  input  logic [PAYLOAD_WIDTH-1:0] flit_payload,
  input  logic [4:0]               flit_sn,
  input  logic [2*XY_WIDTH-1:0]    flit_src,
  output logic                     depack_enable,
  output logic                     core_valid,
  input  logic                     core_ready,
  output logic [PAYLOAD_WIDTH-1:0] core_data,
  output logic [2*XY_WIDTH-1:0]    core_src,
  output logic                     core_sop,
  output logic                     core_eop,
  output logic                     pkt_err,
  output logic [1:0]               err_code,
  output logic [15:0]              pkt_ok_cnt,
  output logic [7:0]               err_cnt
);

  localparam int CNT_W = (MAX_FLITS > 2) ? $clog2(MAX_FLITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FLITS - 1);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [1:0] EC_LENGTH = 2'd0;
  localparam logic [1:0] EC_TYPE   = 2'd1;
  localparam logic [1:0] EC_SEQ    = 2'd2;
  localparam logic [1:0] EC_SRC    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [4:0]            exp_sn, exp_sn_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [2*XY_WIDTH-1:0] pkt_src, pkt_src_nxt;

  logic       consume;
  logic       start_pkt;
  logic       fwd;
  logic       fwd_sop;
  logic       fwd_eop;
  logic       err;
  logic [1:0] err_cause;
  logic       ok_inc;

  // The depacketizer may hand over a flit whenever the slot is empty or is
  // being emptied this very cycle, which gives lossless drain-and-load.
  assign depack_enable = flit_valid & (~core_valid | core_ready);
  assign consume       = depack_enable;

  // Packet checker: decides for the consumed flit whether it is forwarded,
  // dropped, or flagged, and computes the next packet context. A head or
  // single always opens a fresh context regardless of the current state;
  // only in BODY does that also count as a type error (truncated packet).
  always_comb begin
    state_nxt   = state;
    exp_sn_nxt  = exp_sn;
    cnt_nxt     = cnt;
    pkt_src_nxt = pkt_src;
    start_pkt   = 1'b0;
    fwd         = 1'b0;
    fwd_sop     = 1'b0;
    fwd_eop     = 1'b0;
    err         = 1'b0;
    err_cause   = EC_LENGTH;
    ok_inc      = 1'b0;

    if (consume) begin
      if (flit_type == FT_HEAD || flit_type == FT_SINGLE) begin
        start_pkt = 1'b1;
        if (state == BODY) begin
          err       = 1'b1;
          err_cause = EC_TYPE;
        end
      end else begin
        case (state)
          IDLE: begin
            err       = 1'b1;
            err_cause = EC_TYPE;
            state_nxt = (flit_type == FT_BODY) ? DROP : IDLE;
          end
          BODY: begin
            if (flit_src != pkt_src) begin
              err       = 1'b1;
              err_cause = EC_SRC;
            end else if (flit_sn != exp_sn) begin
              err       = 1'b1;
              err_cause = EC_SEQ;
            end else if (flit_type == FT_BODY && cnt == CNT_LAST) begin
              err       = 1'b1;
              err_cause = EC_LENGTH;
            end

            if (err) begin
              state_nxt = (flit_type == FT_BODY) ? DROP : IDLE;
            end else if (flit_type == FT_TAIL) begin
              fwd       = 1'b1;
              fwd_eop   = 1'b1;
              ok_inc    = 1'b1;
              state_nxt = IDLE;
            end else begin
              fwd        = 1'b1;
              exp_sn_nxt = exp_sn + 5'd1;
              cnt_nxt    = cnt + CNT_W'(1);
            end
          end
          DROP: begin
            if (flit_type == FT_TAIL) begin
              state_nxt = IDLE;
            end
          end
          default: begin
            state_nxt = IDLE;
          end
        endcase
      end

      if (start_pkt) begin
        fwd     = 1'b1;
        fwd_sop = 1'b1;
        if (flit_type == FT_SINGLE) begin
          fwd_eop   = 1'b1;
          state_nxt = IDLE;
        end else begin
          pkt_src_nxt = flit_src;
          exp_sn_nxt  = flit_sn + 5'd1;
          cnt_nxt     = CNT_W'(1);
          state_nxt   = BODY;
        end
      end
    end
  end

  // Packet context registers: FSM state plus the expected sequence number,
  // flit count and source of the packet currently being received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      exp_sn  <= '0;
      cnt     <= '0;
      pkt_src <= '0;
    end else begin
      state   <= state_nxt;
      exp_sn  <= exp_sn_nxt;
      cnt     <= cnt_nxt;
      pkt_src <= pkt_src_nxt;
    end
  end

  // Output slot: loaded with every forwarded flit, emptied when the core
  // takes it and nothing new arrives. Dropped flits leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_valid <= 1'b0;
      core_data  <= '0;
      core_src   <= '0;
      core_sop   <= 1'b0;
      core_eop   <= 1'b0;
    end else if (fwd) begin
      core_valid <= 1'b1;
      core_data  <= flit_payload;
      core_src   <= flit_src;
      core_sop   <= fwd_sop;
      core_eop   <= fwd_eop;
    end else if (core_ready) begin
      core_valid <= 1'b0;
    end
  end

  // Error reporting and statistics. err_code is sticky until the next error;
  // err_cnt stops at its maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_err    <= 1'b0;
      err_code   <= EC_LENGTH;
      err_cnt    <= '0;
      pkt_ok_cnt <= '0;
    end else begin
      pkt_err <= err;
      if (err) begin
        err_code <= err_cause;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (ok_inc) begin
        pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_depack_ctrl.sv
// tb_depack_ctrl
// Self-checking bench for depack_ctrl (built with MAX_FLITS=4 so the length
// limit is easy to reach). Directed table vectors, hand-written backpressure
// and reset sequences, then random traffic against a packet-level model.
module tb_depack_ctrl;

  localparam int PW   = 32;
  localparam int XYW  = 4;
  localparam int MAXF = 4;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic            clk;
  logic            rst;
  logic            flit_valid;
  logic [1:0]      flit_type;
  logic [PW-1:0]   flit_payload;
  logic [4:0]      flit_sn;
  logic [2*XYW-1:0] flit_src;
  logic            depack_enable;
  logic            core_valid;
  logic            core_ready;
  logic [PW-1:0]   core_data;
  logic [2*XYW-1:0] core_src;
  logic            core_sop;
  logic            core_eop;
  logic            pkt_err;
  logic [1:0]      err_code;
  logic [15:0]     pkt_ok_cnt;
  logic [7:0]      err_cnt;

  depack_ctrl #(
    .PAYLOAD_WIDTH(PW),
    .XY_WIDTH     (XYW),
    .MAX_FLITS    (MAXF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_valid   (flit_valid),
    .flit_type    (flit_type),
    .flit_payload (flit_payload),
    .flit_sn      (flit_sn),
    .flit_src     (flit_src),
    .depack_enable(depack_enable),
    .core_valid   (core_valid),
    .core_ready   (core_ready),
    .core_data    (core_data),
    .core_src     (core_src),
    .core_sop     (core_sop),
    .core_eop     (core_eop),
    .pkt_err      (pkt_err),
    .err_code     (err_code),
    .pkt_ok_cnt   (pkt_ok_cnt),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Packet-level reference model: what the core should be seeing.
  logic        m_valid;
  logic [31:0] m_data;
  logic [7:0]  m_src;
  logic        m_sop;
  logic        m_eop;
  logic        m_err;
  logic [1:0]  m_code;
  int          m_ok;
  int          m_errc;
  bit          in_pkt;
  bit          discard;
  int          m_exp;
  int          flits;
  logic [7:0]  pkt_src;
  bit          last_take;

  logic [31:0] got[$];

  typedef struct {
    logic [1:0] ftype;
    logic [4:0] sn;
    logic [7:0] src;
    logic       exp_valid;
    logic       exp_sop;
    logic       exp_eop;
    logic       exp_err;
    logic [1:0] exp_code;
    int         exp_okc;
    int         exp_errc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] t, input int sn, input int src,
                              input bit v, input bit sop, input bit eop, input bit e,
                              input int code, input int okc, input int errc);
    vec_t r;
    r.ftype     = t;
    r.sn        = 5'(sn);
    r.src       = 8'(src);
    r.exp_valid = v;
    r.exp_sop   = sop;
    r.exp_eop   = eop;
    r.exp_err   = e;
    r.exp_code  = 2'(code);
    r.exp_okc   = okc;
    r.exp_errc  = errc;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_valid = 1'b0; m_data = '0; m_src = '0; m_sop = 1'b0; m_eop = 1'b0;
    m_err = 1'b0; m_code = 2'd0; m_ok = 0; m_errc = 0;
    in_pkt = 1'b0; discard = 1'b0; m_exp = 0; flits = 0; pkt_src = '0;
    last_take = 1'b0;
  endtask

  // One clock edge of the packet rules applied to the presented flit.
  task automatic modelStep(input logic v, input logic [1:0] t, input logic [4:0] sn,
                           input logic [7:0] src, input logic [31:0] pl, input logic rdy);
    bit take, fwd, err, ok, sop, eop;
    int code;
    take = v && (!m_valid || rdy);
    last_take = take;
    fwd = 0; err = 0; ok = 0; sop = 0; eop = 0; code = 0;
    if (take) begin
      if (t == T_HEAD || t == T_SINGLE) begin
        if (in_pkt) begin err = 1; code = 1; end
        fwd = 1; sop = 1; eop = (t == T_SINGLE);
        in_pkt = (t == T_HEAD); discard = 0;
        m_exp = (int'(sn) + 1) % 32; flits = 1; pkt_src = src;
      end else if (discard) begin
        if (t == T_TAIL) discard = 0;
      end else if (!in_pkt) begin
        err = 1; code = 1; discard = (t == T_BODY);
      end else begin
        if (src != pkt_src) begin err = 1; code = 3; end
        else if (int'(sn) != m_exp) begin err = 1; code = 2; end
        else if (t == T_BODY && flits + 1 >= MAXF) begin err = 1; code = 0; end
        if (err) begin
          in_pkt = 0; discard = (t == T_BODY);
        end else begin
          fwd = 1; eop = (t == T_TAIL);
          if (t == T_TAIL) begin ok = 1; in_pkt = 0; end
          else begin flits++; m_exp = (m_exp + 1) % 32; end
        end
      end
    end
    if (fwd) begin
      m_valid = 1; m_data = pl; m_src = src; m_sop = sop; m_eop = eop;
    end else if (rdy) begin
      m_valid = 0;
    end
    m_err = err;
    if (err) begin
      m_code = 2'(code);
      if (m_errc < 255) m_errc++;
    end
    if (ok) m_ok = (m_ok + 1) % 65536;
  endtask

  task automatic checkOutput();
    checkVal("core_valid", 32'(core_valid), 32'(m_valid));
    checkVal("core_data",  core_data, m_data);
    checkVal("core_src",   32'(core_src), 32'(m_src));
    checkVal("core_sop",   32'(core_sop), 32'(m_sop));
    checkVal("core_eop",   32'(core_eop), 32'(m_eop));
    checkVal("pkt_err",    32'(pkt_err), 32'(m_err));
    checkVal("err_code",   32'(err_code), 32'(m_code));
    checkVal("pkt_ok_cnt", 32'(pkt_ok_cnt), 32'(m_ok));
    checkVal("err_cnt",    32'(err_cnt), 32'(m_errc));
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [4:0] sn,
                               input logic [7:0] src, input logic [31:0] pl, input logic rdy);
    @(negedge clk);
    flit_valid = v; flit_type = t; flit_sn = sn; flit_src = src;
    flit_payload = pl; core_ready = rdy;
    #1;
    checkVal("depack_enable", 32'(depack_enable), 32'(v && (!m_valid || rdy)));
    if (core_valid && core_ready) got.push_back(core_data);
    @(posedge clk);
    modelStep(v, t, sn, src, pl, rdy);
    #1;
    checkOutput();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases just
  // after an edge so the very next edge can already consume a flit.
  task automatic doReset();
    @(negedge clk);
    flit_valid = 1'b0; core_ready = 1'b0; rst = 1'b1;
    #1;
    checkVal("rst core_valid", 32'(core_valid), 32'd0);
    checkVal("rst core_data",  core_data, 32'd0);
    checkVal("rst core_src",   32'(core_src), 32'd0);
    checkVal("rst core_sop",   32'(core_sop), 32'd0);
    checkVal("rst core_eop",   32'(core_eop), 32'd0);
    checkVal("rst pkt_err",    32'(pkt_err), 32'd0);
    checkVal("rst err_code",   32'(err_code), 32'd0);
    checkVal("rst pkt_ok_cnt", 32'(pkt_ok_cnt), 32'd0);
    checkVal("rst err_cnt",    32'(err_cnt), 32'd0);
    modelReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    bit sent;
    int cyc;
    logic [31:0] bp_pl[4];
    logic [1:0]  bp_t[4];
    rst = 1'b1; flit_valid = 1'b0; flit_type = T_BODY; flit_payload = '0;
    flit_sn = '0; flit_src = '0; core_ready = 1'b0;
    modelReset();
    #12;
    doReset();

    // Directed vectors, core_ready held high.
    vq.push_back(mk(T_HEAD,  30, 'h23, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(T_BODY,  31, 'h23, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(T_TAIL,   0, 'h23, 1, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(T_HEAD,   4, 'h23, 1, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk(T_BODY,   6, 'h23, 0, 1, 0, 1, 2, 1, 1));
    vq.push_back(mk(T_BODY,   7, 'h23, 0, 1, 0, 0, 2, 1, 1));
    vq.push_back(mk(T_TAIL,   8, 'h23, 0, 1, 0, 0, 2, 1, 1));
    vq.push_back(mk(T_HEAD,   0, 'h11, 1, 1, 0, 0, 2, 1, 1));
    vq.push_back(mk(T_BODY,   1, 'h12, 0, 1, 0, 1, 3, 1, 2));
    vq.push_back(mk(T_HEAD,   9, 'h11, 1, 1, 0, 0, 3, 1, 2));
    vq.push_back(mk(T_TAIL,  10, 'h11, 1, 0, 1, 0, 3, 2, 2));
    vq.push_back(mk(T_HEAD,   0, 'h11, 1, 1, 0, 0, 3, 2, 2));
    vq.push_back(mk(T_BODY,   1, 'h11, 1, 0, 0, 0, 3, 2, 2));
    vq.push_back(mk(T_BODY,   2, 'h11, 1, 0, 0, 0, 3, 2, 2));
    vq.push_back(mk(T_BODY,   3, 'h11, 0, 0, 0, 1, 0, 2, 3));
    vq.push_back(mk(T_TAIL,   4, 'h11, 0, 0, 0, 0, 0, 2, 3));
    vq.push_back(mk(T_HEAD,   5, 'h11, 1, 1, 0, 0, 0, 2, 3));
    vq.push_back(mk(T_BODY,   6, 'h11, 1, 0, 0, 0, 0, 2, 3));
    vq.push_back(mk(T_BODY,   7, 'h11, 1, 0, 0, 0, 0, 2, 3));
    vq.push_back(mk(T_TAIL,   8, 'h11, 1, 0, 1, 0, 0, 3, 3));
    vq.push_back(mk(T_TAIL,   0, 'h11, 0, 0, 1, 1, 1, 3, 4));
    vq.push_back(mk(T_HEAD,   1, 'h11, 1, 1, 0, 0, 1, 3, 4));
    vq.push_back(mk(T_SINGLE, 5, 'h11, 1, 1, 1, 1, 1, 3, 5));
    vq.push_back(mk(T_BODY,   0, 'h11, 0, 1, 1, 1, 1, 3, 6));
    vq.push_back(mk(T_SINGLE, 0, 'h11, 1, 1, 1, 0, 1, 3, 6));

    foreach (vq[i]) begin
      applyStimulus(1'b1, vq[i].ftype, vq[i].sn, vq[i].src, 32'hA000_0000 + 32'(i), 1'b1);
      checkVal($sformatf("vec%0d valid", i), 32'(core_valid), 32'(vq[i].exp_valid));
      if (vq[i].exp_valid) begin
        checkVal($sformatf("vec%0d sop", i), 32'(core_sop), 32'(vq[i].exp_sop));
        checkVal($sformatf("vec%0d eop", i), 32'(core_eop), 32'(vq[i].exp_eop));
        checkVal($sformatf("vec%0d data", i), core_data, 32'hA000_0000 + 32'(i));
      end
      checkVal($sformatf("vec%0d pkt_err", i), 32'(pkt_err), 32'(vq[i].exp_err));
      checkVal($sformatf("vec%0d err_code", i), 32'(err_code), 32'(vq[i].exp_code));
      checkVal($sformatf("vec%0d ok_cnt", i), 32'(pkt_ok_cnt), 32'(vq[i].exp_okc));
      checkVal($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(vq[i].exp_errc));
    end

    // Backpressure: core stalls for 5 cycles in the middle of a 4-flit packet.
    applyStimulus(1'b0, T_BODY, 5'd0, 8'h00, 32'h0, 1'b1);
    got.delete();
    bp_t[0] = T_HEAD; bp_t[1] = T_BODY; bp_t[2] = T_BODY; bp_t[3] = T_TAIL;
    for (int k = 0; k < 4; k++) bp_pl[k] = 32'hB0B0_0000 + 32'(k * 7 + 3);
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      sent = 1'b0;
      for (int tries = 0; tries < 20 && !sent; tries++) begin
        logic rdy;
        rdy = !(cyc >= 1 && cyc <= 5);
        applyStimulus(1'b1, bp_t[k], 5'(10 + k), 8'h45, bp_pl[k], rdy);
        if (!rdy && core_valid)
          checkVal("bp stall enable", 32'(depack_enable), 32'd0);
        sent = last_take;
        cyc++;
      end
      if (!sent) checkVal("bp flit consumed", 32'd0, 32'd1);
    end
    applyStimulus(1'b0, T_BODY, 5'd0, 8'h00, 32'h0, 1'b1);
    applyStimulus(1'b0, T_BODY, 5'd0, 8'h00, 32'h0, 1'b1);
    checkVal("bp out count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) checkVal($sformatf("bp order %0d", k), got[k], bp_pl[k]);
    end

    // Reset in mid-packet, then a fresh head must start cleanly.
    applyStimulus(1'b1, T_HEAD, 5'd3, 8'h77, 32'hC0DE_0001, 1'b1);
    doReset();
    applyStimulus(1'b1, T_HEAD, 5'd9, 8'h66, 32'hC0DE_0002, 1'b1);
    checkVal("post-rst pkt_err", 32'(pkt_err), 32'd0);
    checkVal("post-rst valid", 32'(core_valid), 32'd1);
    checkVal("post-rst sop", 32'(core_sop), 32'd1);
    applyStimulus(1'b1, T_TAIL, 5'd10, 8'h66, 32'hC0DE_0003, 1'b1);
    checkVal("post-rst ok_cnt", 32'(pkt_ok_cnt), 32'd1);

    // Random traffic, mostly well formed, with random backpressure.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [1:0] t;
      logic [4:0] sn;
      logic [7:0] src;
      r = $urandom_range(0, 9);
      t = (r < 5) ? T_BODY : (r < 7) ? T_TAIL : (r < 9) ? T_HEAD : T_SINGLE;
      sn  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(m_exp);
      src = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pkt_src;
      applyStimulus($urandom_range(0, 3) != 0, t, sn, src, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
